// File: rtl/btb_assoc.sv
// Set-associative branch target buffer: NRD combinational lookup ports, one registered
// update port from EXE, 2-bit direction counters, per-set round-robin replacement, global flush.
module btb_assoc #(
   parameter int         XLEN      = 32,
   parameter int         ENTRY_NUM = 64,
   parameter int         WAYS      = 2,
   parameter int         NRD       = 2,
   parameter logic [1:0] CNT_INIT  = 2'b10
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                flush,
   input  logic [NRD*XLEN-1:0] rd_pc,
   output logic [NRD-1:0]      rd_hit,
   output logic [NRD*XLEN-1:0] rd_target,
   output logic [NRD-1:0]      rd_taken,
   input  logic                upd_valid,
   input  logic                upd_taken,
   input  logic [XLEN-1:0]     upd_pc,
   input  logic [XLEN-1:0]     upd_target
);

   localparam int SETS  = ENTRY_NUM / WAYS;
   localparam int IDX_W = $clog2(SETS);
   localparam int TAG_W = XLEN - 1 - IDX_W;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;

   generate
      if ((ENTRY_NUM <= 0) || ((ENTRY_NUM & (ENTRY_NUM - 1)) != 0)) begin : g_bad_entries
         $error("btb_assoc: ENTRY_NUM must be a power of 2");
      end
      if ((WAYS <= 0) || ((WAYS & (WAYS - 1)) != 0)) begin : g_bad_ways
         $error("btb_assoc: WAYS must be a power of 2");
      end
      if (WAYS > ENTRY_NUM) begin : g_bad_ratio
         $error("btb_assoc: WAYS must not exceed ENTRY_NUM");
      end
   endgenerate

   logic             valid_reg [SETS][WAYS];
   logic [1:0]       cnt_reg   [SETS][WAYS];
   logic [TAG_W-1:0] tag_reg   [SETS][WAYS];
   logic [XLEN-2:0]  tgt_reg   [SETS][WAYS];
   logic [WAY_W-1:0] rr_reg    [SETS];

   genvar gi;
   generate
      for (gi = 0; gi < NRD; gi++) begin : g_rd
         logic [IDX_W-1:0] idx;
         logic [TAG_W-1:0] tag;
         logic             hit;
         logic             taken;
         logic [XLEN-2:0]  tgt;
         logic             lookup_unused;

         assign idx           = rd_pc[gi*XLEN+1 +: IDX_W];
         assign tag           = rd_pc[gi*XLEN+IDX_W+1 +: TAG_W];
         assign lookup_unused = rd_pc[gi*XLEN];

         always_comb begin
            hit   = 1'b0;
            taken = 1'b0;
            tgt   = '0;
            for (int w = 0; w < WAYS; w++) begin
               if (valid_reg[idx][w] && (tag_reg[idx][w] == tag)) begin
                  hit   = 1'b1;
                  taken = cnt_reg[idx][w][1];
                  tgt   = tgt_reg[idx][w];
               end
            end
         end

         assign rd_hit[gi]                  = hit;
         assign rd_taken[gi]                = taken;
         assign rd_target[gi*XLEN +: XLEN]  = {tgt, 1'b0};
      end
   endgenerate

   logic [IDX_W-1:0] upd_idx;
   logic [TAG_W-1:0] upd_tag;
   logic             upd_hit;
   logic [WAY_W-1:0] hit_way;
   logic             free_found;
   logic [WAY_W-1:0] free_way;
   logic [WAY_W-1:0] alloc_way;
   logic [WAY_W-1:0] write_way;
   logic [WAY_W-1:0] rr_next;
   logic [1:0]       upd_cnt;
   logic             upd_unused;

   assign upd_idx    = upd_pc[IDX_W:1];
   assign upd_tag    = upd_pc[XLEN-1:IDX_W+1];
   assign upd_unused = upd_pc[0] ^ upd_target[0];

   always_comb begin
      upd_hit    = 1'b0;
      hit_way    = '0;
      free_found = 1'b0;
      free_way   = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_reg[upd_idx][w] && (tag_reg[upd_idx][w] == upd_tag)) begin
            upd_hit = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
      // Scan downwards so the lowest-numbered invalid way wins.
      for (int w = WAYS - 1; w >= 0; w--) begin
         if (!valid_reg[upd_idx][w]) begin
            free_found = 1'b1;
            free_way   = WAY_W'(w);
         end
      end
   end

   assign alloc_way = free_found ? free_way : rr_reg[upd_idx];
   assign write_way = upd_hit ? hit_way : alloc_way;
   assign rr_next   = (rr_reg[upd_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_reg[upd_idx] + 1'b1;
   assign upd_cnt   = cnt_reg[upd_idx][hit_way];

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         for (int s = 0; s < SETS; s++) begin
            rr_reg[s] <= '0;
            for (int w = 0; w < WAYS; w++) begin
               valid_reg[s][w] <= 1'b0;
               cnt_reg[s][w]   <= 2'b00;
            end
         end
      end else if (flush) begin
         for (int s = 0; s < SETS; s++) begin
            for (int w = 0; w < WAYS; w++) begin
               valid_reg[s][w] <= 1'b0;
            end
         end
      end else if (upd_valid) begin
         if (upd_hit) begin
            if (upd_taken) begin
               if (upd_cnt != 2'b11) cnt_reg[upd_idx][hit_way] <= upd_cnt + 2'b01;
            end else if (upd_cnt != 2'b00) begin
               cnt_reg[upd_idx][hit_way] <= upd_cnt - 2'b01;
            end else begin
               valid_reg[upd_idx][hit_way] <= 1'b0;
            end
         end else if (upd_taken) begin
            valid_reg[upd_idx][alloc_way] <= 1'b1;
            cnt_reg[upd_idx][alloc_way]   <= CNT_INIT;
            if (!free_found) rr_reg[upd_idx] <= rr_next;
         end
      end
   end

   // Tag and target payload carry no reset; they are only meaningful under valid.
   always_ff @(posedge clk) begin
      if (reset_n && !flush && upd_valid && upd_taken) begin
         tgt_reg[upd_idx][write_way] <= upd_target[XLEN-1:1];
         if (!upd_hit) tag_reg[upd_idx][write_way] <= upd_tag;
      end
   end

endmodule

// File: tb/tb_btb_assoc.sv
// Directed bench for btb_assoc: table of per-cycle vectors plus hand-written reset sequence.
module tb_btb_assoc;

   localparam int XLEN = 32;
   localparam int NRD  = 2;

   logic                clk = 1'b0;
   logic                reset_n;
   logic                flush;
   logic [NRD*XLEN-1:0] rd_pc;
   logic [NRD-1:0]      rd_hit;
   logic [NRD*XLEN-1:0] rd_target;
   logic [NRD-1:0]      rd_taken;
   logic                upd_valid;
   logic                upd_taken;
   logic [XLEN-1:0]     upd_pc;
   logic [XLEN-1:0]     upd_target;

   int tests  = 0;
   int failed = 0;

   btb_assoc dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .flush      (flush),
      .rd_pc      (rd_pc),
      .rd_hit     (rd_hit),
      .rd_target  (rd_target),
      .rd_taken   (rd_taken),
      .upd_valid  (upd_valid),
      .upd_taken  (upd_taken),
      .upd_pc     (upd_pc),
      .upd_target (upd_target)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        uv;
      logic        ut;
      logic [31:0] upc;
      logic [31:0] utgt;
      logic        fl;
      logic [31:0] pc0;
      logic [31:0] pc1;
      logic [1:0]  hit;
      logic [31:0] t0;
      logic [31:0] t1;
      logic [1:0]  tk;
   } vec_t;

   vec_t vecs[$];

   function automatic void add(logic uv, logic ut, logic [31:0] upc, logic [31:0] utgt,
                               logic fl, logic [31:0] pc0, logic [31:0] pc1,
                               logic [1:0] hit, logic [31:0] t0, logic [31:0] t1,
                               logic [1:0] tk);
      vec_t v;
      v.uv = uv; v.ut = ut; v.upc = upc; v.utgt = utgt; v.fl = fl;
      v.pc0 = pc0; v.pc1 = pc1; v.hit = hit; v.t0 = t0; v.t1 = t1; v.tk = tk;
      vecs.push_back(v);
   endfunction

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         failed++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(logic uv, logic ut, logic [31:0] upc, logic [31:0] utgt,
                        logic fl, logic [31:0] pc0, logic [31:0] pc1);
      upd_valid  = uv;
      upd_taken  = ut;
      upd_pc     = upc;
      upd_target = utgt;
      flush      = fl;
      rd_pc      = {pc1, pc0};
   endtask

   task automatic check_out(string tag, logic [1:0] hit, logic [31:0] t0, logic [31:0] t1,
                            logic [1:0] tk);
      chk({tag, " hit"}, 32'(rd_hit), 32'(hit));
      chk({tag, " tgt0"}, rd_target[31:0], t0);
      chk({tag, " tgt1"}, rd_target[63:32], t1);
      chk({tag, " taken"}, 32'(rd_taken), 32'(tk));
      $display("[TB] %s pc0=%0h pc1=%0h hit=%b tgt0=%0h tgt1=%0h taken=%b",
               tag, rd_pc[31:0], rd_pc[63:32], rd_hit, rd_target[31:0], rd_target[63:32], rd_taken);
   endtask

   initial begin
      // Each row: inputs for one cycle; expectations reflect state before that cycle's update.
      add(0,0,32'h0,   32'h0,   0, 32'h100, 32'h100, 2'b00, 32'h0,    32'h0,    2'b00);
      add(1,1,32'h100, 32'h2001,0, 32'h100, 32'h100, 2'b00, 32'h0,    32'h0,    2'b00);
      add(0,0,32'h0,   32'h0,   0, 32'h100, 32'h100, 2'b11, 32'h2000, 32'h2000, 2'b11);
      add(1,0,32'h100, 32'h0,   0, 32'h100, 32'h100, 2'b11, 32'h2000, 32'h2000, 2'b11);
      add(1,0,32'h100, 32'h0,   0, 32'h100, 32'h100, 2'b11, 32'h2000, 32'h2000, 2'b00);
      add(1,0,32'h100, 32'h0,   0, 32'h100, 32'h100, 2'b11, 32'h2000, 32'h2000, 2'b00);
      add(1,0,32'h100, 32'h0,   0, 32'h100, 32'h140, 2'b00, 32'h0,    32'h0,    2'b00);
      add(0,0,32'h0,   32'h0,   0, 32'h100, 32'h140, 2'b00, 32'h0,    32'h0,    2'b00);
      add(1,1,32'h100, 32'hA00, 0, 32'h100, 32'h140, 2'b00, 32'h0,    32'h0,    2'b00);
      add(1,1,32'h140, 32'hB00, 0, 32'h100, 32'h140, 2'b01, 32'hA00,  32'h0,    2'b01);
      add(1,1,32'h180, 32'hC00, 0, 32'h100, 32'h140, 2'b11, 32'hA00,  32'hB00,  2'b11);
      add(0,0,32'h0,   32'h0,   0, 32'h100, 32'h140, 2'b10, 32'h0,    32'hB00,  2'b10);
      add(1,1,32'h180, 32'hD00, 0, 32'h140, 32'h180, 2'b11, 32'hB00,  32'hC00,  2'b11);
      add(0,0,32'h0,   32'h0,   0, 32'h140, 32'h180, 2'b11, 32'hB00,  32'hD00,  2'b11);
      add(1,1,32'h1C0, 32'hE00, 0, 32'h180, 32'h1C0, 2'b01, 32'hD00,  32'h0,    2'b01);
      add(0,0,32'h0,   32'h0,   0, 32'h140, 32'h1C0, 2'b10, 32'h0,    32'hE00,  2'b10);
      add(0,0,32'h0,   32'h0,   0, 32'h180, 32'h181, 2'b11, 32'hD00,  32'hD00,  2'b11);
      add(1,1,32'h204, 32'h3001,0, 32'h204, 32'h180, 2'b10, 32'h0,    32'hD00,  2'b10);
      for (int i = 0; i < 4; i++)
         add(1,1,32'h204, 32'h3000,0, 32'h204, 32'h180, 2'b11, 32'h3000, 32'hD00, 2'b11);
      add(1,0,32'h204, 32'h0,   0, 32'h204, 32'h180, 2'b11, 32'h3000, 32'hD00,  2'b11);
      add(1,0,32'h204, 32'h0,   0, 32'h204, 32'h180, 2'b11, 32'h3000, 32'hD00,  2'b11);
      add(0,0,32'h0,   32'h0,   0, 32'h204, 32'h180, 2'b11, 32'h3000, 32'hD00,  2'b10);
      add(1,1,32'h300, 32'h4000,1, 32'h204, 32'h180, 2'b11, 32'h3000, 32'hD00,  2'b10);
      add(0,0,32'h0,   32'h0,   0, 32'h300, 32'h180, 2'b00, 32'h0,    32'h0,    2'b00);
      add(0,0,32'h0,   32'h0,   0, 32'h204, 32'h1C0, 2'b00, 32'h0,    32'h0,    2'b00);

      reset_n = 1'b0;
      drive(0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
      repeat (2) @(negedge clk);
      reset_n = 1'b1;

      foreach (vecs[i]) begin
         @(negedge clk);
         drive(vecs[i].uv, vecs[i].ut, vecs[i].upc, vecs[i].utgt, vecs[i].fl,
               vecs[i].pc0, vecs[i].pc1);
         #1;
         check_out($sformatf("vec%0d", i), vecs[i].hit, vecs[i].t0, vecs[i].t1, vecs[i].tk);
      end

      // Mid-stream reset: repopulate, then hold reset_n low for one cycle with an update pending.
      @(negedge clk);
      drive(1, 1, 32'h100, 32'h1234, 0, 32'h100, 32'h140);
      @(negedge clk);
      drive(0, 0, 32'h0, 32'h0, 0, 32'h100, 32'h140);
      #1;
      check_out("refill", 2'b01, 32'h1234, 32'h0, 2'b01);
      @(negedge clk);
      reset_n = 1'b0;
      drive(1, 1, 32'h140, 32'h5000, 0, 32'h100, 32'h140);
      #1;
      check_out("in_reset", 2'b01, 32'h1234, 32'h0, 2'b01);
      @(negedge clk);
      reset_n = 1'b1;
      drive(0, 0, 32'h0, 32'h0, 0, 32'h100, 32'h140);
      #1;
      check_out("post_reset", 2'b00, 32'h0, 32'h0, 2'b00);
      @(negedge clk);
      drive(1, 1, 32'h140, 32'h6000, 0, 32'h100, 32'h140);
      @(negedge clk);
      drive(0, 0, 32'h0, 32'h0, 0, 32'h100, 32'h140);
      #1;
      check_out("realloc", 2'b10, 32'h0, 32'h6000, 2'b10);

      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

endmodule
